// File: rtl/regbank_pkg.sv
// Shared types and constants for the multi-port register bank: jump encodings,
// the hard-wired zero register and the location of the instruction pointer.
package regbank_pkg;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_REL  = 2'b01,
    JUMP_ABS  = 2'b10,
    JUMP_RSVD = 2'b11
  } jump_mode_t;

  localparam int REG_ZERO = 0;

  // The instruction pointer occupies the topmost architectural index.
  function automatic int ip_index(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Load-pending scoreboard: one busy bit per register, set by a reserve, cleared
// by any enabled write, with a read-side lookup that honours same-cycle writes.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int NUM_WRITE = 2,
  parameter int NUM_READ  = 2,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    ReserveEnable,
  input  logic [AW-1:0]           ReserveAddress,
  input  logic [NUM_WRITE-1:0]    WriteEnable,
  input  logic [NUM_WRITE*AW-1:0] WriteAddress,
  input  logic [NUM_READ*AW-1:0]  ReadAddress,
  output logic [NUM_READ-1:0]     ReadBusy
);

  localparam logic [AW-1:0] IPX = AW'(ip_index(NUM_REGS));

  logic [NUM_REGS-1:0] busy_p0;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [AW-1:0]       wa;
  logic [AW-1:0]       ra;

  // Decode this cycle's enabled writes and reserve; 0 and IPX never track loads.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    wa      = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (Enable && WriteEnable[w]) begin
        wa         = WriteAddress[w*AW +: AW];
        wr_hit[wa] = 1'b1;
      end
    end
    if (Enable && ReserveEnable) begin
      rsv_hit[ReserveAddress] = 1'b1;
    end
    wr_hit[REG_ZERO]  = 1'b0;
    wr_hit[IPX]       = 1'b0;
    rsv_hit[REG_ZERO] = 1'b0;
    rsv_hit[IPX]      = 1'b0;
  end

  // A reserve landing with a write means a newer load is outstanding: set wins.
  always_comb begin
    busy_nxt = busy_p0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rsv_hit[r]) begin
        busy_nxt[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  // ---- stage p0: busy state ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_p0 <= '0;
    end else begin
      busy_p0 <= busy_nxt;
    end
  end

  always_comb begin
    ReadBusy = '0;
    ra       = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra          = ReadAddress[i*AW +: AW];
      ReadBusy[i] = busy_p0[ra];
      if ((BYPASS != 0) && wr_hit[ra] && !rsv_hit[ra]) begin
        ReadBusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port architectural register file with integrated instruction pointer,
// prioritised write ports, optional same-cycle write bypass and a load scoreboard.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          NUM_REGS  = 16,
  parameter int          NUM_READ  = 2,
  parameter int          NUM_WRITE = 2,
  parameter int          IP_INC    = 2,
  parameter int unsigned RESET_IP  = 0,
  parameter int          BYPASS    = 1,
  localparam int         AW        = $clog2(NUM_REGS)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic [NUM_READ*AW-1:0]      ReadAddress,
  output logic [NUM_READ*DATA_W-1:0]  ReadData,
  output logic [NUM_READ-1:0]         ReadBusy,
  input  logic [NUM_WRITE-1:0]        WriteEnable,
  input  logic [NUM_WRITE*AW-1:0]     WriteAddress,
  input  logic [NUM_WRITE*DATA_W-1:0] WriteData,
  input  logic                        ReserveEnable,
  input  logic [AW-1:0]               ReserveAddress,
  input  logic [1:0]                  JumpMode,
  input  logic [DATA_W-1:0]           JumpTarget,
  output logic [DATA_W-1:0]           InstructionPointerOut
);

  localparam logic [AW-1:0]     IPX     = AW'(ip_index(NUM_REGS));
  localparam logic [DATA_W-1:0] IP_RST  = DATA_W'(RESET_IP);
  localparam logic [DATA_W-1:0] IP_STEP = DATA_W'(IP_INC);

  logic [DATA_W-1:0]   regs_p0 [NUM_REGS];
  logic [DATA_W-1:0]   ip_p0;
  logic [DATA_W-1:0]   ip_nxt;
  logic [DATA_W-1:0]   wr_data [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [AW-1:0]       wa;
  logic [AW-1:0]       ra;
  jump_mode_t          jmode;

  assign jmode = jump_mode_t'(JumpMode);

  // Per-register write arbitration: later (higher-index) ports overwrite earlier ones.
  always_comb begin
    wr_hit = '0;
    wa     = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_data[r] = '0;
    end
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (Enable && WriteEnable[w]) begin
        wa          = WriteAddress[w*AW +: AW];
        wr_hit[wa]  = 1'b1;
        wr_data[wa] = WriteData[w*DATA_W +: DATA_W];
      end
    end
    wr_hit[REG_ZERO] = 1'b0;
    wr_hit[IPX]      = 1'b0;
  end

  // Reserved jump encoding falls through to the sequential increment.
  always_comb begin
    ip_nxt = ip_p0 + IP_STEP;
    case (jmode)
      JUMP_REL: ip_nxt = ip_p0 + JumpTarget;
      JUMP_ABS: ip_nxt = JumpTarget;
      default:  ip_nxt = ip_p0 + IP_STEP;
    endcase
  end

  // ---- stage p0: architectural state ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip_p0 <= IP_RST;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_p0[r] <= '0;
      end
    end else if (Enable) begin
      ip_p0 <= ip_nxt;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_p0[r] <= wr_data[r];
        end
      end
    end
  end

  assign InstructionPointerOut = ip_p0;

  always_comb begin
    ReadData = '0;
    ra       = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = ReadAddress[i*AW +: AW];
      if (ra == AW'(REG_ZERO)) begin
        ReadData[i*DATA_W +: DATA_W] = '0;
      end else if (ra == IPX) begin
        ReadData[i*DATA_W +: DATA_W] = ip_p0;
      end else if ((BYPASS != 0) && wr_hit[ra]) begin
        ReadData[i*DATA_W +: DATA_W] = wr_data[ra];
      end else begin
        ReadData[i*DATA_W +: DATA_W] = regs_p0[ra];
      end
    end
  end

  regbank_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_WRITE (NUM_WRITE),
    .NUM_READ  (NUM_READ),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .Clock          (Clock),
    .Reset          (Reset),
    .Enable         (Enable),
    .ReserveEnable  (ReserveEnable),
    .ReserveAddress (ReserveAddress),
    .WriteEnable    (WriteEnable),
    .WriteAddress   (WriteAddress),
    .ReadAddress    (ReadAddress),
    .ReadBusy       (ReadBusy)
  );

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: a 16-bit/16-register instance and a
// 32-bit/32-register/3-read instance, both with RESET_IP = 0x0100.
module tb_regbank_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---- instance A: 16 x 16, 2 read, 2 write ----
  logic        a_rst, a_en, a_rsv_en;
  logic [7:0]  a_ra, a_wa;
  logic [31:0] a_rd, a_wd;
  logic [1:0]  a_rb, a_we, a_jm;
  logic [3:0]  a_rsv_a;
  logic [15:0] a_jt, a_ip;

  regbank_mp #(
    .DATA_W(16), .NUM_REGS(16), .NUM_READ(2), .NUM_WRITE(2),
    .IP_INC(2), .RESET_IP(32'h0100), .BYPASS(1)
  ) dut_a (
    .Clock(clk), .Reset(a_rst), .Enable(a_en),
    .ReadAddress(a_ra), .ReadData(a_rd), .ReadBusy(a_rb),
    .WriteEnable(a_we), .WriteAddress(a_wa), .WriteData(a_wd),
    .ReserveEnable(a_rsv_en), .ReserveAddress(a_rsv_a),
    .JumpMode(a_jm), .JumpTarget(a_jt), .InstructionPointerOut(a_ip)
  );

  // ---- instance B: 32 x 32, 3 read, 2 write ----
  logic        b_rst, b_en, b_rsv_en;
  logic [14:0] b_ra;
  logic [95:0] b_rd;
  logic [2:0]  b_rb;
  logic [1:0]  b_we, b_jm;
  logic [9:0]  b_wa;
  logic [63:0] b_wd;
  logic [4:0]  b_rsv_a;
  logic [31:0] b_jt, b_ip;

  regbank_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_READ(3), .NUM_WRITE(2),
    .IP_INC(2), .RESET_IP(32'h0100), .BYPASS(1)
  ) dut_b (
    .Clock(clk), .Reset(b_rst), .Enable(b_en),
    .ReadAddress(b_ra), .ReadData(b_rd), .ReadBusy(b_rb),
    .WriteEnable(b_we), .WriteAddress(b_wa), .WriteData(b_wd),
    .ReserveEnable(b_rsv_en), .ReserveAddress(b_rsv_a),
    .JumpMode(b_jm), .JumpTarget(b_jt), .InstructionPointerOut(b_ip)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_rsv_en = 1'b0; a_rsv_a = '0;
    a_ra = '0; a_wa = '0; a_wd = '0; a_we = '0; a_jm = '0; a_jt = '0;
    b_rst = 1'b1; b_en = 1'b0; b_rsv_en = 1'b0; b_rsv_a = '0;
    b_ra = '0; b_wa = '0; b_wd = '0; b_we = '0; b_jm = '0; b_jt = '0;

    // ---------------- instance A ----------------
    tick(); tick();
    a_rst = 1'b0;
    a_ra = {4'd15, 4'd3};
    #1;
    check_eq("a_rst_ip", a_ip, 32'h0100);
    check_eq("a_rst_rd0", a_rd[15:0], 32'h0);
    check_eq("a_rst_rd_ipx", a_rd[31:16], 32'h0100);
    check_eq("a_rst_busy", a_rb, 32'h0);

    a_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("a_ip_seq", a_ip, 32'h0100 + 2 * k);
    end

    // same-address writes on both ports: port1 wins, visible same cycle
    a_we = 2'b11; a_wa = {4'd3, 4'd3}; a_wd = {16'h2222, 16'h1111};
    a_ra = {4'd1, 4'd3};
    #1;
    check_eq("a_bypass_r3", a_rd[15:0], 32'h2222);
    tick();
    a_we = '0;
    #1;
    check_eq("a_reg_r3", a_rd[15:0], 32'h2222);
    check_eq("a_ip_0108", a_ip, 32'h0108);

    a_jm = 2'b10; a_jt = 16'hFFFE;
    tick();
    check_eq("a_abs_fffe", a_ip, 32'hFFFE);
    a_jm = 2'b01; a_jt = 16'h0004;
    tick();
    check_eq("a_rel_wrap", a_ip, 32'h0002);

    // absolute jump with link write to r14
    a_jm = 2'b10; a_jt = 16'h0040;
    a_we = 2'b01; a_wa = {4'd0, 4'd14}; a_wd = {16'h0, 16'h0100};
    tick();
    a_we = '0; a_jm = 2'b00;
    a_ra = {4'd15, 4'd14};
    #1;
    check_eq("a_abs_ip", a_ip, 32'h0040);
    check_eq("a_link_r14", a_rd[15:0], 32'h0100);
    check_eq("a_rd_ipx", a_rd[31:16], 32'h0040);

    // writes to r0 and IPX are dropped and never bypassed
    a_we = 2'b11; a_wa = {4'd15, 4'd0}; a_wd = {16'h7777, 16'h5555};
    a_ra = {4'd15, 4'd0};
    #1;
    check_eq("a_r0_nobyp", a_rd[15:0], 32'h0);
    check_eq("a_ipx_nobyp", a_rd[31:16], 32'h0040);
    tick();
    a_we = '0;
    #1;
    check_eq("a_r0_zero", a_rd[15:0], 32'h0);
    check_eq("a_ipx_ip", a_rd[31:16], 32'h0042);

    // reserve r5, load returns on port1 two cycles later
    a_rsv_en = 1'b1; a_rsv_a = 4'd5; a_ra = {4'd0, 4'd5};
    tick();
    a_rsv_en = 1'b0;
    #1;
    check_eq("a_r5_busy1", a_rb[0], 32'h1);
    tick();
    check_eq("a_r5_busy2", a_rb[0], 32'h1);
    a_we = 2'b10; a_wa = {4'd5, 4'd0}; a_wd = {16'hBEEF, 16'h0};
    #1;
    check_eq("a_r5_busy_mask", a_rb[0], 32'h0);
    check_eq("a_r5_byp", a_rd[15:0], 32'hBEEF);
    tick();
    a_we = '0;
    #1;
    check_eq("a_r5_busy_clr", a_rb[0], 32'h0);
    check_eq("a_r5_data", a_rd[15:0], 32'hBEEF);

    // reserve and write r7 in one cycle: busy survives
    a_rsv_en = 1'b1; a_rsv_a = 4'd7;
    a_we = 2'b01; a_wa = {4'd0, 4'd7}; a_wd = {16'h0, 16'h1234};
    a_ra = {4'd7, 4'd0};
    tick();
    a_rsv_en = 1'b0; a_we = '0;
    #1;
    check_eq("a_r7_busy", a_rb[1], 32'h1);
    check_eq("a_r7_data", a_rd[31:16], 32'h1234);
    check_eq("a_ip_004a", a_ip, 32'h004A);

    // Enable low: writes, jump and reserve must all be ignored
    a_en = 1'b0;
    a_we = 2'b11; a_wa = {4'd9, 4'd8}; a_wd = {16'hAAAA, 16'hBBBB};
    a_jm = 2'b10; a_jt = 16'h0300;
    a_rsv_en = 1'b1; a_rsv_a = 4'd10;
    a_ra = {4'd9, 4'd8};
    #1;
    check_eq("a_dis_nobyp", a_rd, 32'h0);
    tick(); tick();
    check_eq("a_dis_ip", a_ip, 32'h004A);
    check_eq("a_dis_regs", a_rd, 32'h0);
    a_en = 1'b1; a_we = '0; a_jm = '0; a_rsv_en = 1'b0;
    a_ra = {4'd7, 4'd10};
    #1;
    check_eq("a_dis_busy", a_rb, 32'h2);

    // reserve r9 with data in flight, then reset mid-load
    a_rsv_en = 1'b1; a_rsv_a = 4'd9;
    a_we = 2'b01; a_wa = {4'd0, 4'd9}; a_wd = {16'h0, 16'h9999};
    a_ra = {4'd3, 4'd9};
    tick();
    a_rsv_en = 1'b0; a_we = '0;
    #1;
    check_eq("a_r9_pre", a_rd[15:0], 32'h9999);
    check_eq("a_r9_busy_pre", a_rb[0], 32'h1);
    check_eq("a_r3_pre", a_rd[31:16], 32'h2222);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    #1;
    check_eq("a_rst2_ip", a_ip, 32'h0100);
    check_eq("a_rst2_busy", a_rb, 32'h0);
    check_eq("a_rst2_regs", a_rd, 32'h0);
    a_we = 2'b01; a_wa = {4'd0, 4'd9}; a_wd = {16'h0, 16'h4321};
    tick();
    a_we = '0;
    #1;
    check_eq("a_late_data", a_rd[15:0], 32'h4321);
    check_eq("a_late_busy", a_rb, 32'h0);
    check_eq("a_late_ip", a_ip, 32'h0102);

    // ---------------- instance B ----------------
    tick();
    b_rst = 1'b0;
    b_ra = {5'd3, 5'd0, 5'd31};
    #1;
    check_eq("b_rst_ip", b_ip, 32'h0100);
    check_eq("b_rst_rd_ipx", b_rd[31:0], 32'h0100);
    check_eq("b_rst_rd_r0", b_rd[63:32], 32'h0);
    check_eq("b_rst_rd_r3", b_rd[95:64], 32'h0);
    check_eq("b_rst_busy", b_rb, 32'h0);
    b_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("b_ip_seq", b_ip, 32'h0100 + 2 * k);
    end
    b_jm = 2'b10; b_jt = 32'hFFFF_FFFE;
    tick();
    check_eq("b_abs", b_ip, 32'hFFFF_FFFE);
    b_jm = 2'b01; b_jt = 32'h0000_0004;
    b_we = 2'b10; b_wa = {5'd3, 5'd0}; b_wd = {32'hDEAD_BEEF, 32'h0};
    tick();
    b_jm = 2'b00; b_we = '0;
    #1;
    check_eq("b_rel_wrap", b_ip, 32'h0000_0002);
    check_eq("b_r3", b_rd[95:64], 32'hDEAD_BEEF);
    check_eq("b_rd_ipx", b_rd[31:0], 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
